aes_dec_round_seq: RTL and testbench
====================================

Name: aes_dec_round_seq

Overview:
- Round sequencer that drives the 128-bit ALU through a full AES inverse cipher on one 128-bit ciphertext block.
- Fetches round keys from an external synchronous round-key store and issues the DECF / DEC / XORE opcodes in order.
- Holds the running state between ALU passes and returns plaintext through a valid/ready handshake.
- Sits between the CPU decrypt-instruction issue logic and the ALU operand/opcode muxes.

Parameters:
- NUM_ROUNDS, 10, AES round count (10/12/14). The block performs NUM_ROUNDS+1 ALU passes.
- KEY_AW, 4, round-key store address width. Must satisfy 2**KEY_AW > NUM_ROUNDS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ciphertext offered.
- in_ready  out  1  block accepts ciphertext.
- in_data  in  128  ciphertext.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer takes plaintext.
- out_data  out  128  plaintext.
- key_rd_en  out  1  round-key read strobe.
- key_rd_addr  out  KEY_AW  round-key index.
- key_rd_data  in  128  key word; valid the cycle after key_rd_en.
- alu_a  out  128  ALU operand A (running state).
- alu_b  out  128  ALU operand B; equals key_rd_data.
- alu_op  out  5  ALU opcode.
- alu_res  in  128  combinational ALU result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- States: IDLE, FETCH, EXEC, DONE. Registers:
  - st: 128-bit running state.
  - rnd: pass counter, 0..NUM_ROUNDS.
- Reset (rst_n=0, any state): state=IDLE, st=0, rnd=0, out_valid=0, key_rd_en=0, key_rd_addr=0, alu_op=5'h00, busy=0. This holds even mid-decryption; the in-flight block is discarded with no output.
- in_ready=1 only in IDLE, including the first cycle after reset release.
- IDLE: on in_valid&in_ready, st<=in_data, rnd<=0, go to FETCH.
- FETCH: key_rd_en=1.
  - key_rd_addr = NUM_ROUNDS when rnd=0; otherwise NUM_ROUNDS-rnd.
  - Next state is EXEC.
- EXEC: alu_a=st, alu_b=key_rd_data. Opcode by pass:
  - rnd=0: alu_op=5'h14 (DECF).
  - 1<=rnd<=NUM_ROUNDS-1: alu_op=5'h13 (DEC).
  - rnd=NUM_ROUNDS: alu_op=5'h15 (XORE).
  - At the clock edge, st<=alu_res.
  - If rnd==NUM_ROUNDS, go to DONE. Otherwise rnd<=rnd+1 and go to FETCH.
- Outside EXEC: alu_op=5'h00 and alu_a=st, alu_b=0. The ALU passes A through.
- key_rd_addr holds its value from FETCH through EXEC.
- DONE: out_valid=1 and out_data=st, both stable until out_ready. On out_ready, go to IDLE.
- out_data=st in all states; it is only meaningful when out_valid=1.
- Latency: out_valid rises 2*(NUM_ROUNDS+1) rising edges after the accepting edge, which is 22 edges for NUM_ROUNDS=10.
- A new block can be accepted no earlier than one cycle after the out_ready handshake.
- in_valid during FETCH/EXEC/DONE is ignored. The upstream holds it, since in_ready=0.
- out_ready outside DONE has no effect.
- rnd never exceeds NUM_ROUNDS and never wraps.

Optional Feature:
- Macro: AES_DEC_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in FETCH or EXEC: next state is IDLE, rnd<=0, st unchanged, no out_valid.
  - abort=1 in DONE or IDLE: ignored.
  - If abort and in_valid are both high in IDLE, the block is accepted normally.
- Undefined: no abort port, and every accepted block runs to DONE.

Test Plan:
- FIPS-197 C.1 (AES-128). Key store holds the expansion of key 000102030405060708090a0b0c0d0e0f at indices 0..10; in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data=00112233445566778899aabbccddeeff.
  - Required: out_valid rises exactly 22 edges after accept.
- Opcode/address trace for the same block:
  - EXEC sequence is alu_op 14,13×9,15.
  - key_rd_addr sequence is 10,9,...,1,0.
  - key_rd_en pulses once per FETCH, 11 total.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Required: out_valid and out_data stable, in_ready=0.
  - Required: out_ready=1 gives IDLE and in_ready=1 on the following cycle.
- Busy blocking: in_valid=1 with new data during EXEC of rnd=4.
  - Required: no accept, st unaffected, first result still correct.
- Reset mid-operation: drop rst_n asynchronously during EXEC of rnd=6.
  - Required: all outputs at reset values immediately, with no out_valid.
  - Required: after release, a fresh FIPS vector decrypts correctly.
- Abort (AES_DEC_ABORT_EN defined): assert abort in FETCH of rnd=3.
  - Required: IDLE next cycle, out_valid never asserts, next block decrypts correctly.

Source files
------------

// File: rtl/aes_dec_round_seq_if.sv
// Bus bundle for the AES decrypt round sequencer: ciphertext in, plaintext out,
// round-key store read port and ALU operand/opcode port.
interface aes_dec_round_seq_if #(
  parameter int KEY_AW = 4
);
  // Handshakes: a beat transfers on a rising edge where valid and ready are both
  // high; once raised, valid and its data stay stable until that edge.
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_data;
  logic              key_rd_en;
  logic [KEY_AW-1:0] key_rd_addr;
  logic [127:0]      key_rd_data;
  logic [127:0]      alu_a;
  logic [127:0]      alu_b;
  logic [4:0]        alu_op;
  logic [127:0]      alu_res;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready, key_rd_data, alu_res,
    input  in_ready, out_valid, out_data, key_rd_en, key_rd_addr,
           alu_a, alu_b, alu_op, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, key_rd_data, alu_res,
    output in_ready, out_valid, out_data, key_rd_en, key_rd_addr,
           alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/aes_dec_round_seq.sv
// Sequences NUM_ROUNDS+1 ALU passes (DECF, DEC..., XORE) to decrypt one AES block.
// Optional macro AES_DEC_ABORT_EN adds an abort input that cancels a block in flight.
module aes_dec_round_seq #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_AW     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_DEC_ABORT_EN
  input  logic                abort,
`endif
  aes_dec_round_seq_if.slave  bus,
  output logic [1:0]          o_dbg_state
);

  localparam logic [KEY_AW-1:0] LAST_RND = KEY_AW'(NUM_ROUNDS);
  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_DEC  = 5'h13;
  localparam logic [4:0] OP_DECF = 5'h14;
  localparam logic [4:0] OP_XORE = 5'h15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [127:0]      r_st;
  logic [KEY_AW-1:0] r_rnd;
  logic              w_last;
  logic              w_abort;

  assign w_last = (r_rnd == LAST_RND);

`ifdef AES_DEC_ABORT_EN
  assign w_abort = abort & ((r_state == S_FETCH) | (r_state == S_EXEC));
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Key index counts down from the last round key; it stays put across FETCH and EXEC.
  always_comb begin
    w_next          = r_state;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.key_rd_en   = 1'b0;
    bus.key_rd_addr = '0;
    bus.alu_op      = OP_NOP;
    bus.alu_b       = '0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.key_rd_en   = 1'b1;
        bus.key_rd_addr = LAST_RND - r_rnd;
        w_next          = w_abort ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        bus.key_rd_addr = LAST_RND - r_rnd;
        bus.alu_b       = bus.key_rd_data;
        if (r_rnd == '0)  bus.alu_op = OP_DECF;
        else if (w_last)  bus.alu_op = OP_XORE;
        else              bus.alu_op = OP_DEC;
        if (w_abort)      w_next = S_IDLE;
        else if (w_last)  w_next = S_DONE;
        else              w_next = S_FETCH;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Running state and pass counter; an abort leaves the state register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= '0;
      r_rnd <= '0;
    end else if (w_abort) begin
      r_rnd <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_st  <= bus.in_data;
            r_rnd <= '0;
          end
        end
        S_EXEC: begin
          r_st <= bus.alu_res;
          if (!w_last) r_rnd <= r_rnd + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_a    = r_st;
  assign bus.out_data = r_st;
  assign bus.busy     = (r_state != S_IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_aes_dec_round_seq.sv
// Bench for aes_dec_round_seq: AES-128 reference (tables, key schedule, forward cipher)
// drives a round-key store and ALU model, and checks plaintext, trace and handshakes.
module tb_aes_dec_round_seq;
  localparam int NR = 10;
  localparam int AW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
`ifdef AES_DEC_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_dec_round_seq_if #(.KEY_AW(AW)) bus();

  aes_dec_round_seq #(.NUM_ROUNDS(NR), .KEY_AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_DEC_ABORT_EN
    .abort       (abort),
`endif
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox[256];
  logic [7:0]   inv_sbox[256];
  logic [127:0] rk[16];

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic init_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   cf[4];
    logic [7:0]   acc;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(cf[(k - r + 4) % 4], s[127-8*(4*c+k) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher: random plaintexts are encrypted here, and the DUT must recover them.
  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < NR; r++)
      s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
    return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[NR];
  endfunction

  // ---------------- external round-key store and ALU ----------------
  always @(posedge clk)
    if (bus.key_rd_en) bus.key_rd_data <= rk[bus.key_rd_addr];

  always_comb begin
    case (bus.alu_op)
      5'h14:   bus.alu_res = bus.alu_a ^ bus.alu_b;
      5'h13:   bus.alu_res = mix_columns(sub_bytes(shift_rows(bus.alu_a, 1'b1), 1'b1) ^ bus.alu_b, 1'b1);
      5'h15:   bus.alu_res = sub_bytes(shift_rows(bus.alu_a, 1'b1), 1'b1) ^ bus.alu_b;
      default: bus.alu_res = bus.alu_a;
    endcase
  end

  // ---------------- driver: one block through the sequencer ----------------
  // stop_j is the sample index at which a reset (do_reset) or abort is injected.
  task automatic run_block(input logic [127:0] ct, input int hold, input int intrude_j,
                           input int stop_j, input bit do_reset, input string name);
    logic [127:0]  exp;
    logic [12:0]   act;
    logic [12:0]   ev;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [4:0]    e_op;
    logic          e_ov;
    int            r;
    int            waitc;
    int            seen;
    exp   = exp_q.pop_front();
    waitc = 0;
    @(negedge clk);
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready got %b exp 1", name, bus.in_ready);
      return;
    end
    bus.in_data  = ct;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int j = 0; j <= 2*NR + 2; j++) begin
      if (j > 0) @(negedge clk);
      if (j == intrude_j) begin
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_valid = 1'b1;
      end
      if (j == 2*NR + 2) bus.in_valid = 1'b0;
      if (j == stop_j) begin
        if (do_reset) begin
          #2 rst_n = 1'b0;
          #1;
          checks++;
          if ({bus.in_ready, bus.out_valid, bus.busy, bus.key_rd_en, bus.key_rd_addr, bus.alu_op,
               bus.out_data, bus.alu_a, bus.alu_b} !== {1'b1, 1'b0, 1'b0, 1'b0, AW'(0), 5'h00,
               128'h0, 128'h0, 128'h0}) begin
            errors++;
            $display("FAIL %s async_reset got rdy=%b ov=%b busy=%b en=%b addr=%h op=%h out=%h a=%h b=%h exp 1 0 0 0 0 00 and zero data",
                     name, bus.in_ready, bus.out_valid, bus.busy, bus.key_rd_en, bus.key_rd_addr,
                     bus.alu_op, bus.out_data, bus.alu_a, bus.alu_b);
          end
          @(negedge clk);
          rst_n = 1'b1;
        end else begin
`ifdef AES_DEC_ABORT_EN
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          checks++;
          if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s abort_idle got rdy/busy/ov=%b exp 100", name,
                     {bus.in_ready, bus.busy, bus.out_valid});
          end
`endif
        end
        seen = 0;
        repeat (2*NR + 4) begin
          @(negedge clk);
          if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
          errors++;
          $display("FAIL %s no_out_valid got %0d cycles exp 0", name, seen);
        end
        return;
      end
      if (j == 2*NR + 2) begin
        e_en = 1'b0; e_addr = '0; e_op = 5'h00; e_ov = 1'b1;
      end else if (j % 2 == 0) begin
        r = j / 2;
        e_en = 1'b1; e_addr = AW'(NR - r); e_op = 5'h00; e_ov = 1'b0;
      end else begin
        r = (j - 1) / 2;
        e_en = 1'b0; e_addr = AW'(NR - r); e_ov = 1'b0;
        e_op = (r == 0) ? 5'h14 : ((r == NR) ? 5'h15 : 5'h13);
      end
      ev  = {e_en, e_addr, e_op, e_ov, 1'b0, 1'b1};
      act = {bus.key_rd_en, bus.key_rd_addr, bus.alu_op, bus.out_valid, bus.in_ready, bus.busy};
      checks++;
      if (act !== ev) begin
        errors++;
        $display("FAIL %s trace j=%0d got en/addr/op/ov/rdy/busy=%h exp %h", name, j, act, ev);
      end
    end
    checks++;
    if (bus.out_data !== exp) begin
      errors++;
      $display("FAIL %s plaintext got %h exp %h", name, bus.out_data, exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_data} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL %s backpressure h=%0d got ov=%b rdy=%b out=%h exp 1 0 %h",
                 name, h, bus.out_valid, bus.in_ready, bus.out_data, exp);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL %s release got rdy/ov/busy=%b exp 100", name,
               {bus.in_ready, bus.out_valid, bus.busy});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.key_rd_en, bus.key_rd_addr, bus.alu_op, bus.out_data}
        !== {1'b1, 1'b0, 1'b0, 1'b0, AW'(0), 5'h00, 128'h0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b ov=%b busy=%b en=%b addr=%h op=%h out=%h exp 1 0 0 0 0 00 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.key_rd_en, bus.key_rd_addr, bus.alu_op, bus.out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release got %b exp 1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL idle_out_ready got busy/ov/rdy=%b exp 001", {bus.busy, bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_fips();
    exp_q.push_back(FIPS_PT);
    run_block(FIPS_CT, 0, -1, -1, 1'b0, "fips");
  endtask

  task automatic test_backpressure();
    exp_q.push_back(FIPS_PT);
    run_block(FIPS_CT, 5, -1, -1, 1'b0, "backpressure");
  endtask

  task automatic test_busy_block();
    exp_q.push_back(FIPS_PT);
    run_block(FIPS_CT, 0, 9, -1, 1'b0, "busy_block");
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(FIPS_PT);
    run_block(FIPS_CT, 0, -1, 13, 1'b1, "reset_mid");
    exp_q.push_back(FIPS_PT);
    run_block(FIPS_CT, 0, -1, -1, 1'b0, "after_reset");
  endtask

`ifdef AES_DEC_ABORT_EN
  task automatic test_abort();
    exp_q.push_back(FIPS_PT);
    run_block(FIPS_CT, 0, -1, 6, 1'b0, "abort");
    exp_q.push_back(FIPS_PT);
    run_block(FIPS_CT, 0, -1, -1, 1'b0, "after_abort");
  endtask
`endif

  task automatic test_back_to_back();
    logic [127:0] pt;
    for (int n = 0; n < 6; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(pt);
      run_block(aes_encrypt(pt), $urandom_range(0, 3), -1, -1, 1'b0, "random");
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    init_tables();
    expand_key(FIPS_KEY);
    test_reset();
    test_fips();
    test_backpressure();
    test_busy_block();
    test_reset_mid();
`ifdef AES_DEC_ABORT_EN
    test_abort();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
